id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

Decode-to-execute pipeline register with load-use hazard detection, branch flush and halt drain. Captures the control bundles produced by the decode control unit together with operands, immediate and register addresses, and presents them to the execute stage one cycle later. Inserts bubbles on hazards and redirects, back-pressures fetch/decode, and sequences the processor into a halted state after HLT.

## Interface
Parameters:
- DATA_W, 32, operand/PC/immediate width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- de_valid  in  1  decode holds a valid instruction
- de_halt  in  1  decoded opcode is HLT
- de_pc  in  DATA_W  PC of decoded instruction
- de_ex_ctrl  in  15  EX control bundle
- de_ma_ctrl  in  2  MA control bundle
- de_wb_ctrl  in  3  WB control bundle
- de_rs1_addr, de_rs2_addr, de_rd_addr  in  REG_AW each  register addresses
- de_rs1_data, de_rs2_data, de_imm  in  DATA_W each  operands, sign-extended immediate
- ex_flush  in  1  taken branch/jump resolved in EX this cycle
- mem_stall  in  1  downstream memory not ready; freeze
- de_stall  out  1  hold fetch and decode this cycle
- ex_valid, ex_halt  out  1  registered valid / HLT flag
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W  registered copies
- ex_ex_ctrl / ex_ma_ctrl / ex_wb_ctrl  out  15 / 2 / 3  registered bundles
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  REG_AW  registered addresses
- halted  out  1  pipeline drained after HLT

## Operation
- Bubble: valid=0, all bundles and data zero (CC_WE, JMP, BXX, MA_EN, WB_R_WE all 0).
- Load-use hazard (hz): ex_valid & ex_ma_ctrl[MA_EN] & !ex_ma_ctrl[MA_RW] & ex_wb_ctrl[WB_R_WE] & de_valid & ((de_ex_ctrl[EX_NEED_RS1] & de_rs1_addr==ex_rd_addr) | (de_ex_ctrl[EX_NEED_RS2] & de_rs2_addr==ex_rd_addr)). X on a NEED bit counts as 0.
- Per-cycle priority, state RUN:
  - mem_stall: register holds; de_stall=1.
  - else ex_flush: load bubble; de_stall=0 (decoded instruction is wrong-path, discarded).
  - else hz: load bubble; de_stall=1.
  - else: load decode inputs (bubble if !de_valid); de_stall=0.
- Halt FSM states RUN, DRAIN, HALTED:
  - RUN→DRAIN when a valid de_halt is loaded (not on flush/stall/mem_stall cycles); drain counter := 3.
  - DRAIN: de_stall=1; load bubbles; counter decrements on cycles without mem_stall; at 0 → HALTED. ex_flush ignored.
  - HALTED: halted=1, de_stall=1, register holds bubble; exit only via reset.
- Reset mid-operation: all state cleared immediately, asynchronously.

## Timing
- Latency: one cycle decode→EX outputs.
- de_stall is combinational from registered outputs and decode inputs; no registered path.
- Reset values: all outputs 0, state RUN, halted=0, de_stall=0.
- Load-use costs exactly one bubble; the following cycle hz is false (EX holds a bubble).
- HLT loaded at edge N → halted=1 after edge N+3 with no mem_stall.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds outputs stall_cnt and flush_cnt (32 bits each, reset 0, saturating at all-ones). stall_cnt increments on each hz bubble; flush_cnt on each cycle ex_flush is honoured.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Field positions (EX_NEED_RS1, EX_NEED_RS2, MA_EN, MA_RW, WB_R_WE) and bundle widths come from the shared pipelinedefs.v; halt-state encodings and drain depth (3) belong there too.
- One combinational sub-module: id_ex_hazard_detect, computing hz.

## Test plan
- Reset with rst_n=0 mid-stream -> all outputs 0, state RUN, no clock edge required.
- LD r3 followed by ADD r4,r3,r5 (NEED_RS1=1) -> one bubble in EX, de_stall=1 one cycle, ADD enters next cycle.
- LD r3 followed by ADD r4,r1,#5 (bit16=1, NEED_RS2=0, rs1=r1) -> no stall.
- ex_flush=1 with valid decode -> ex_valid=0 next cycle, de_stall=0; simultaneous hz ignored.
- mem_stall=1 for 2 cycles with ex_flush=1 -> outputs frozen, flush not honoured until mem_stall falls.
- HLT loaded -> DRAIN 3 cycles (4 with one mem_stall cycle) -> halted=1, de_stall=1 held until reset; with ID_EX_PERF_CNT_EN, counters match injected events.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX definitions: control-bundle widths, field positions, halt FSM states and drain depth.
package id_ex_stage_reg_pkg;

    localparam int EX_CTRL_W = 15;
    localparam int MA_CTRL_W = 2;
    localparam int WB_CTRL_W = 3;

    localparam int EX_NEED_RS1 = 0;
    localparam int EX_NEED_RS2 = 1;
    localparam int MA_EN       = 0;
    localparam int MA_RW       = 1;
    localparam int WB_R_WE     = 0;

    localparam int PERF_CNT_W  = 32;

    // HLT plus three trailing bubbles must clear before the core reports halted
    localparam int DRAIN_CNT_W = 2;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_DEPTH = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detection between the load held in EX and the instruction in decode.
module id_ex_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              de_valid_i,
    input  logic              de_need_rs1_i,
    input  logic              de_need_rs2_i,
    input  logic [REG_AW-1:0] de_rs1_addr_i,
    input  logic [REG_AW-1:0] de_rs2_addr_i,
    output logic              hz_o
);

    logic needRs1;
    logic needRs2;

    // An unknown NEED bit must never manufacture a stall
    assign needRs1 = (de_need_rs1_i === 1'b1);
    assign needRs2 = (de_need_rs2_i === 1'b1);

    assign hz_o = ex_load_i & de_valid_i &
                  ((needRs1 & (de_rs1_addr_i == ex_rd_addr_i)) |
                   (needRs2 & (de_rs2_addr_i == ex_rd_addr_i)));

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with load-use bubbles, flush, and HLT drain sequencing.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 de_valid,
    input  logic                 de_halt,
    input  logic [DATA_W-1:0]    de_pc,
    input  logic [EX_CTRL_W-1:0] de_ex_ctrl,
    input  logic [MA_CTRL_W-1:0] de_ma_ctrl,
    input  logic [WB_CTRL_W-1:0] de_wb_ctrl,
    input  logic [REG_AW-1:0]    de_rs1_addr,
    input  logic [REG_AW-1:0]    de_rs2_addr,
    input  logic [REG_AW-1:0]    de_rd_addr,
    input  logic [DATA_W-1:0]    de_rs1_data,
    input  logic [DATA_W-1:0]    de_rs2_data,
    input  logic [DATA_W-1:0]    de_imm,
    input  logic                 ex_flush,
    input  logic                 mem_stall,
    output logic                 de_stall,
    output logic                 ex_valid,
    output logic                 ex_halt,
    output logic [DATA_W-1:0]    ex_pc,
    output logic [DATA_W-1:0]    ex_rs1_data,
    output logic [DATA_W-1:0]    ex_rs2_data,
    output logic [DATA_W-1:0]    ex_imm,
    output logic [EX_CTRL_W-1:0] ex_ex_ctrl,
    output logic [MA_CTRL_W-1:0] ex_ma_ctrl,
    output logic [WB_CTRL_W-1:0] ex_wb_ctrl,
    output logic [REG_AW-1:0]    ex_rs1_addr,
    output logic [REG_AW-1:0]    ex_rs2_addr,
    output logic [REG_AW-1:0]    ex_rd_addr,
    output logic                 halted
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    typedef struct packed {
        logic                 valid;
        logic                 halt;
        logic [DATA_W-1:0]    pc;
        logic [EX_CTRL_W-1:0] exCtrl;
        logic [MA_CTRL_W-1:0] maCtrl;
        logic [WB_CTRL_W-1:0] wbCtrl;
        logic [REG_AW-1:0]    rs1Addr;
        logic [REG_AW-1:0]    rs2Addr;
        logic [REG_AW-1:0]    rdAddr;
        logic [DATA_W-1:0]    rs1Data;
        logic [DATA_W-1:0]    rs2Data;
        logic [DATA_W-1:0]    imm;
    } stage_t;

    stage_t                 stage_q, stage_d, deStage;
    halt_state_e            haltState_q;
    logic [DRAIN_CNT_W-1:0] drainCnt_q;
    logic                   halted_q;
    logic                   exLoad, hz;
    logic                   loadHalt, hzBubble, flushTaken;

    assign exLoad = stage_q.valid & stage_q.maCtrl[MA_EN] & ~stage_q.maCtrl[MA_RW] &
                    stage_q.wbCtrl[WB_R_WE];

    id_ex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_load_i     (exLoad),
        .ex_rd_addr_i  (stage_q.rdAddr),
        .de_valid_i    (de_valid),
        .de_need_rs1_i (de_ex_ctrl[EX_NEED_RS1]),
        .de_need_rs2_i (de_ex_ctrl[EX_NEED_RS2]),
        .de_rs1_addr_i (de_rs1_addr),
        .de_rs2_addr_i (de_rs2_addr),
        .hz_o          (hz)
    );

    always_comb begin
        deStage = '0;
        if (de_valid) begin
            deStage.valid   = 1'b1;
            deStage.halt    = de_halt;
            deStage.pc      = de_pc;
            deStage.exCtrl  = de_ex_ctrl;
            deStage.maCtrl  = de_ma_ctrl;
            deStage.wbCtrl  = de_wb_ctrl;
            deStage.rs1Addr = de_rs1_addr;
            deStage.rs2Addr = de_rs2_addr;
            deStage.rdAddr  = de_rd_addr;
            deStage.rs1Data = de_rs1_data;
            deStage.rs2Data = de_rs2_data;
            deStage.imm     = de_imm;
        end
    end

    // mem_stall freezes everything; in RUN a flush outranks the load-use bubble
    always_comb begin
        stage_d    = stage_q;
        de_stall   = 1'b0;
        loadHalt   = 1'b0;
        hzBubble   = 1'b0;
        flushTaken = 1'b0;
        case (haltState_q)
            ST_RUN: begin
                if (mem_stall) begin
                    de_stall = 1'b1;
                end else if (ex_flush) begin
                    stage_d    = '0;
                    flushTaken = 1'b1;
                end else if (hz) begin
                    stage_d  = '0;
                    de_stall = 1'b1;
                    hzBubble = 1'b1;
                end else begin
                    stage_d  = deStage;
                    loadHalt = de_valid & de_halt;
                end
            end
            ST_DRAIN: begin
                de_stall = 1'b1;
                if (!mem_stall) stage_d = '0;
            end
            default: begin
                de_stall = 1'b1;
                stage_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haltState_q <= ST_RUN;
            drainCnt_q  <= '0;
            halted_q    <= 1'b0;
        end else begin
            case (haltState_q)
                ST_RUN: begin
                    if (loadHalt) begin
                        haltState_q <= ST_DRAIN;
                        drainCnt_q  <= DRAIN_DEPTH;
                    end
                end
                ST_DRAIN: begin
                    if (!mem_stall) begin
                        if (drainCnt_q == 2'd1) begin
                            haltState_q <= ST_HALTED;
                            halted_q    <= 1'b1;
                        end
                        drainCnt_q <= drainCnt_q - 2'd1;
                    end
                end
                default: halted_q <= 1'b1;
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stallCnt_q, flushCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (hzBubble && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 1'b1;
            if (flushTaken && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + 1'b1;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;
`endif

    assign ex_valid    = stage_q.valid;
    assign ex_halt     = stage_q.halt;
    assign ex_pc       = stage_q.pc;
    assign ex_ex_ctrl  = stage_q.exCtrl;
    assign ex_ma_ctrl  = stage_q.maCtrl;
    assign ex_wb_ctrl  = stage_q.wbCtrl;
    assign ex_rs1_addr = stage_q.rs1Addr;
    assign ex_rs2_addr = stage_q.rs2Addr;
    assign ex_rd_addr  = stage_q.rdAddr;
    assign ex_rs1_data = stage_q.rs1Data;
    assign ex_rs2_data = stage_q.rs2Data;
    assign ex_imm      = stage_q.imm;
    assign halted      = halted_q;

endmodule
